// File: rtl/xbar_peri_nx.sv
// rtl/xbar_peri_nx.sv - TileLink-UL 1:N peripheral crossbar with in-order response gating and unmapped error responder
// Optional XBAR_PERI_D_REG_EN inserts a 2-entry skid register on the host D channel.
module xbar_peri_nx #(
    parameter int N_SLV        = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int SIZE_WIDTH   = 3,
    parameter int SRC_WIDTH    = 2,
    parameter int SINK_WIDTH   = 1,
    parameter int OPCODE_WIDTH = 3,
    parameter int PARAM_WIDTH  = 3,
    parameter logic [N_SLV*ADDR_WIDTH-1:0] SLV_BASE = (N_SLV*ADDR_WIDTH)'(
        256'h1000_7000_1000_6000_1000_5000_1000_4000_1000_3000_1000_2000_1000_1000_1000_0000),
    parameter logic [N_SLV*ADDR_WIDTH-1:0] SLV_MASK = (N_SLV*ADDR_WIDTH)'({8{32'hFFFF_F000}}),
    parameter int MAX_OUT      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [OPCODE_WIDTH-1:0]       a_opcode,
    input  logic [PARAM_WIDTH-1:0]        a_param,
    input  logic [SIZE_WIDTH-1:0]         a_size,
    input  logic [SRC_WIDTH-1:0]          a_source,
    input  logic [ADDR_WIDTH-1:0]         a_address,
    input  logic [MASK_WIDTH-1:0]         a_mask,
    input  logic [DATA_WIDTH-1:0]         a_data,
    output logic                          d_valid,
    input  logic                          d_ready,
    output logic [OPCODE_WIDTH-1:0]       d_opcode,
    output logic [PARAM_WIDTH-1:0]        d_param,
    output logic [SIZE_WIDTH-1:0]         d_size,
    output logic [SRC_WIDTH-1:0]          d_source,
    output logic [SINK_WIDTH-1:0]         d_sink,
    output logic [DATA_WIDTH-1:0]         d_data,
    output logic                          d_error,
    output logic [N_SLV-1:0]              a_valid_out,
    input  logic [N_SLV-1:0]              a_ready_out,
    output logic [OPCODE_WIDTH-1:0]       a_opcode_out,
    output logic [PARAM_WIDTH-1:0]        a_param_out,
    output logic [SIZE_WIDTH-1:0]         a_size_out,
    output logic [SRC_WIDTH-1:0]          a_source_out,
    output logic [ADDR_WIDTH-1:0]         a_address_out,
    output logic [MASK_WIDTH-1:0]         a_mask_out,
    output logic [DATA_WIDTH-1:0]         a_data_out,
    input  logic [N_SLV-1:0]              d_valid_in,
    output logic [N_SLV-1:0]              d_ready_in,
    input  logic [N_SLV*OPCODE_WIDTH-1:0] d_opcode_in,
    input  logic [N_SLV*PARAM_WIDTH-1:0]  d_param_in,
    input  logic [N_SLV*SIZE_WIDTH-1:0]   d_size_in,
    input  logic [N_SLV*SRC_WIDTH-1:0]    d_source_in,
    input  logic [N_SLV*SINK_WIDTH-1:0]   d_sink_in,
    input  logic [N_SLV*DATA_WIDTH-1:0]   d_data_in,
    input  logic [N_SLV-1:0]              d_error_in
);
    localparam int TW    = $clog2(N_SLV + 1);
    localparam int CW    = 4;
    localparam int PKT_W = OPCODE_WIDTH + PARAM_WIDTH + SIZE_WIDTH + SRC_WIDTH
                         + SINK_WIDTH + DATA_WIDTH + 1;
    localparam logic [TW-1:0] UNMAPPED = TW'(N_SLV);

    logic [TW-1:0]           tgt;
    logic [TW-1:0]           cur_tgt;
    logic [CW-1:0]           out_cnt;
    logic [N_SLV-1:0]        hit_oh;
    logic [N_SLV-1:0]        cur_oh;
    logic                    mapped;
    logic                    gate;
    logic                    a_fire;
    logic                    d_fire;
    logic                    cur_is_err;
    logic                    slv_valid;
    logic [PKT_W-1:0]        slv_pkt;
    logic                    src_valid;
    logic                    src_ready;
    logic                    src_pend;
    logic                    src_fire;
    logic [PKT_W-1:0]        src_pkt;
    logic [PKT_W-1:0]        d_pkt;
    logic                    err_valid;
    logic                    err_get;
    logic [SIZE_WIDTH-1:0]   err_size;
    logic [SRC_WIDTH-1:0]    err_source;

    // Descending scan so the lowest matching slave index wins.
    always_comb begin
        tgt    = UNMAPPED;
        hit_oh = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((a_address & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                tgt       = TW'(i);
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
        end
    end

    assign mapped = (tgt != UNMAPPED);
    assign gate   = mapped ? ((out_cnt < CW'(MAX_OUT)) && ((out_cnt == '0) || (tgt == cur_tgt)))
                           : (out_cnt == '0);

    assign a_valid_out   = (reset && a_valid && gate) ? hit_oh : '0;
    assign a_ready       = reset && gate && (mapped ? |(a_ready_out & hit_oh) : 1'b1);
    assign a_fire        = a_valid && a_ready;
    assign a_opcode_out  = a_opcode;
    assign a_param_out   = a_param;
    assign a_size_out    = a_size;
    assign a_source_out  = a_source;
    assign a_address_out = a_address;
    assign a_mask_out    = a_mask;
    assign a_data_out    = a_data;

    always_comb begin
        cur_oh    = '0;
        slv_valid = 1'b0;
        slv_pkt   = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (cur_tgt == TW'(i)) begin
                cur_oh[i] = 1'b1;
                slv_valid = d_valid_in[i];
                slv_pkt   = {d_opcode_in[i*OPCODE_WIDTH +: OPCODE_WIDTH],
                             d_param_in[i*PARAM_WIDTH +: PARAM_WIDTH],
                             d_size_in[i*SIZE_WIDTH +: SIZE_WIDTH],
                             d_source_in[i*SRC_WIDTH +: SRC_WIDTH],
                             d_sink_in[i*SINK_WIDTH +: SINK_WIDTH],
                             d_data_in[i*DATA_WIDTH +: DATA_WIDTH],
                             d_error_in[i]};
            end
        end
    end

    assign cur_is_err = (cur_tgt == UNMAPPED);
    assign src_valid  = cur_is_err ? err_valid : (slv_valid && src_pend);
    assign src_pkt    = cur_is_err ? {OPCODE_WIDTH'(err_get), PARAM_WIDTH'(0), err_size, err_source,
                                      SINK_WIDTH'(0), DATA_WIDTH'(0), 1'b1}
                                   : slv_pkt;
    assign src_fire   = src_valid && src_ready;
    assign d_ready_in = (reset && src_pend && src_ready) ? cur_oh : '0;

`ifdef XBAR_PERI_D_REG_EN
    logic [PKT_W-1:0] skid_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_cnt;

    // Only slave beats not already captured in the skid count as pending.
    assign src_pend  = (out_cnt > {2'b00, fifo_cnt});
    assign src_ready = (fifo_cnt != 2'd2);
    assign d_valid   = (fifo_cnt != 2'd0);
    assign d_pkt     = skid_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (src_fire) begin
            skid_mem[wr_ptr] <= src_pkt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (src_fire) wr_ptr <= ~wr_ptr;
            if (d_fire)   rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, src_fire} - {1'b0, d_fire};
        end
    end
`else
    assign src_pend  = (out_cnt != '0);
    assign src_ready = d_ready;
    assign d_valid   = src_valid;
    assign d_pkt     = src_pkt;
`endif

    assign {d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error} = d_pkt;
    assign d_fire = d_valid && d_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_cnt    <= '0;
            cur_tgt    <= '0;
            err_valid  <= 1'b0;
            err_get    <= 1'b0;
            err_size   <= '0;
            err_source <= '0;
        end else begin
            if (a_fire) begin
                cur_tgt <= tgt;
            end
            case ({a_fire, d_fire})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
            // Get (opcode 4) is answered with AccessAckData, everything else with AccessAck.
            if (a_fire && !mapped) begin
                err_valid  <= 1'b1;
                err_get    <= (a_opcode == OPCODE_WIDTH'(4));
                err_size   <= a_size;
                err_source <= a_source;
            end else if (src_fire && cur_is_err) begin
                err_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_xbar_peri_nx.sv
// tb/tb_xbar_peri_nx.sv - directed self-checking bench for xbar_peri_nx
module tb_xbar_peri_nx;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode, a_param, a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address, a_data;
    logic [3:0]  a_mask;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode, d_param, d_size;
    logic [1:0]  d_source;
    logic        d_sink, d_error;
    logic [31:0] d_data;
    logic [3:0]  a_valid_out, a_ready_out;
    logic [2:0]  a_opcode_out, a_param_out, a_size_out;
    logic [1:0]  a_source_out;
    logic [31:0] a_address_out, a_data_out;
    logic [3:0]  a_mask_out;
    logic [3:0]  d_valid_in, d_ready_in, d_sink_in, d_error_in;
    logic [11:0] d_opcode_in, d_param_in, d_size_in;
    logic [7:0]  d_source_in;
    logic [127:0] d_data_in;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [37:0] dq[$];
    int          tq[$];

    xbar_peri_nx dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
        .d_source(d_source), .d_sink(d_sink), .d_data(d_data), .d_error(d_error),
        .a_valid_out(a_valid_out), .a_ready_out(a_ready_out), .a_opcode_out(a_opcode_out),
        .a_param_out(a_param_out), .a_size_out(a_size_out), .a_source_out(a_source_out),
        .a_address_out(a_address_out), .a_mask_out(a_mask_out), .a_data_out(a_data_out),
        .d_valid_in(d_valid_in), .d_ready_in(d_ready_in), .d_opcode_in(d_opcode_in),
        .d_param_in(d_param_in), .d_size_in(d_size_in), .d_source_in(d_source_in),
        .d_sink_in(d_sink_in), .d_data_in(d_data_in), .d_error_in(d_error_in)
    );

    always #5 clk = ~clk;

    // Host-side D beat log: {error, opcode, source, data} plus the cycle it fired.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset === 1'b1 && d_valid === 1'b1 && d_ready === 1'b1) begin
            dq.push_back({d_error, d_opcode, d_source, d_data});
            tq.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive_a(input logic [2:0] opc, input logic [31:0] addr, input logic [1:0] src);
        a_valid = 1'b1; a_opcode = opc; a_address = addr; a_source = src;
        a_size = 3'd2; a_mask = 4'hF; a_data = 32'h0;
    endtask

    task automatic issue(input logic [2:0] opc, input logic [31:0] addr, input logic [1:0] src);
        bit ok = 0;
        drive_a(opc, addr, src);
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (a_ready) ok = 1;
            @(posedge clk); #1;
        end
        if (!ok) check("issue_timeout", 0, 1);
        a_valid = 1'b0;
    endtask

    task automatic respond(input int s, input logic [31:0] data, input logic [1:0] src, input logic [2:0] opc);
        bit ok = 0;
        d_valid_in[s] = 1'b1;
        d_data_in[s*32 +: 32] = data;
        d_source_in[s*2 +: 2] = src;
        d_opcode_in[s*3 +: 3] = opc;
        d_error_in[s] = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (d_ready_in[s]) ok = 1;
            @(posedge clk); #1;
        end
        if (!ok) check("respond_timeout", 0, 1);
        d_valid_in[s] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [37:0] e;
        bit ok;
        a_valid = 0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
        a_address = 0; a_mask = 0; a_data = 0; d_ready = 1; a_ready_out = 4'hF;
        d_valid_in = 0; d_sink_in = 0; d_error_in = 0; d_opcode_in = 0; d_param_in = 0;
        d_size_in = 0; d_source_in = 0; d_data_in = 0;

        drive_a(3'd4, 32'h1000_0000, 2'd0);
        #12;
        check("rst_a_ready", a_ready, 0);
        check("rst_a_valid_out", a_valid_out, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_d_ready_in", d_ready_in, 0);
        a_valid = 0;
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_d_valid", d_valid, 0);
        check("idle_a_valid_out", a_valid_out, 0);
        check("idle_d_ready_in", d_ready_in, 0);
        @(posedge clk); #1;

        // Get to slave1
        drive_a(3'd4, 32'h1000_1004, 2'd1);
        @(negedge clk);
        check("get1_a_valid_out", a_valid_out, 4'b0010);
        check("get1_a_ready", a_ready, 1);
        check("get1_addr_out", a_address_out, 32'h1000_1004);
        @(posedge clk); #1 a_valid = 0;
        check("get1_out_cnt", dut.out_cnt, 1);
        respond(1, 32'hCAFE_0001, 2'd1, 3'd1);
        repeat (3) @(posedge clk); #1;
        check("get1_out_cnt_done", dut.out_cnt, 0);
        check("get1_beats", dq.size(), 1);
        e = (dq.size() > 0) ? dq.pop_front() : 38'h0;
        check("get1_d_data", e[31:0], 32'hCAFE_0001);
        check("get1_d_error", e[37], 0);
        check("get1_d_source", e[33:32], 2'd1);

        // Unmapped Get
        drive_a(3'd4, 32'h2000_0000, 2'd2);
        @(negedge clk);
        check("unm_a_valid_out", a_valid_out, 0);
        check("unm_a_ready", a_ready, 1);
        @(posedge clk); #1 a_valid = 0;
`ifdef XBAR_PERI_D_REG_EN
        @(posedge clk); #1;
`endif
        @(negedge clk);
        check("unm_d_valid", d_valid, 1);
        check("unm_d_opcode", d_opcode, 3'd1);
        check("unm_d_error", d_error, 1);
        check("unm_d_source", d_source, 2'd2);
        check("unm_d_data", d_data, 32'h0);
        check("unm_d_size", d_size, 3'd2);
        repeat (2) @(posedge clk); #1;
        check("unm_out_cnt", dut.out_cnt, 0);
        dq.delete(); tq.delete();

        // MAX_OUT stall
        for (int k = 0; k < 4; k++) issue(3'd0, 32'h1000_0000, 2'(k));
        check("max_out_cnt", dut.out_cnt, 4);
        drive_a(3'd0, 32'h1000_0010, 2'd0);
        @(negedge clk);
        check("max_a_ready_stall", a_ready, 0);
        check("max_a_valid_out_stall", a_valid_out, 0);
        @(posedge clk); #1;
        respond(0, 32'h0, 2'd0, 3'd0);
        ok = 0;
        for (int n = 0; n < 5 && !ok; n++) begin
            @(negedge clk);
            if (a_ready) ok = 1; else begin @(posedge clk); #1; end
        end
        check("max_fifth_accepted", ok, 1);
        @(posedge clk); #1 a_valid = 0;
        for (int k = 0; k < 4; k++) respond(0, 32'h0, 2'd0, 3'd0);
        repeat (3) @(posedge clk); #1;
        check("max_out_cnt_done", dut.out_cnt, 0);
        check("max_beats", dq.size(), 5);
        dq.delete(); tq.delete();

        // Target switch waits for in-flight response
        issue(3'd4, 32'h1000_0000, 2'd0);
        drive_a(3'd4, 32'h1000_2000, 2'd1);
        @(negedge clk);
        check("sw_a_ready_blocked", a_ready, 0);
        check("sw_a_valid_out_blocked", a_valid_out, 0);
        @(posedge clk); #1;
        respond(0, 32'h11, 2'd0, 3'd1);
        ok = 0;
        for (int n = 0; n < 5 && !ok; n++) begin
            @(negedge clk);
            if (a_valid_out != 0) ok = 1; else begin @(posedge clk); #1; end
        end
        check("sw_a_valid_out", a_valid_out, 4'b0100);
        @(posedge clk); #1 a_valid = 0;
        respond(2, 32'h22, 2'd1, 3'd1);
        repeat (3) @(posedge clk); #1;
        check("sw_beats", dq.size(), 2);
        check("sw_second_data", (dq.size() > 1) ? dq[1][31:0] : 32'h0, 32'h22);
        dq.delete(); tq.delete();

        // Reset mid-flight
        issue(3'd4, 32'h1000_3000, 2'd0);
        issue(3'd4, 32'h1000_3000, 2'd1);
        check("rst2_out_cnt", dut.out_cnt, 2);
        d_valid_in[3] = 1'b1; d_data_in[127:96] = 32'hDEAD_0000;
        #2 reset = 1'b0;
        #1;
        check("rst2_out_cnt_clr", dut.out_cnt, 0);
        check("rst2_d_valid", d_valid, 0);
        check("rst2_d_ready_in", d_ready_in, 0);
        d_valid_in = 0;
        dq.delete(); tq.delete();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        issue(3'd4, 32'h1000_3000, 2'd3);
        respond(3, 32'hBEEF_0003, 2'd3, 3'd1);
        repeat (3) @(posedge clk); #1;
        check("rst2_beats", dq.size(), 1);
        e = (dq.size() > 0) ? dq.pop_front() : 38'h0;
        check("rst2_d_data", e[31:0], 32'hBEEF_0003);
        check("rst2_d_source", e[33:32], 2'd3);
        dq.delete(); tq.delete();

`ifdef XBAR_PERI_D_REG_EN
        begin
            int acc0 = 0;
            fork
                begin
                    drive_a(3'd4, 32'h1000_1000, 2'd0);
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        check("b2b_a_ready", a_ready, 1);
                        @(posedge clk);
                    end
                    #1 a_valid = 0;
                end
                begin
                    @(posedge clk); #1;
                    d_valid_in[1] = 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        d_data_in[63:32] = 32'(k);
                        @(negedge clk);
                        if (k == 0) acc0 = cyc;
                        check("b2b_d_ready_in", d_ready_in[1], 1);
                        @(posedge clk); #1;
                    end
                    d_valid_in[1] = 1'b0;
                end
            join
            repeat (4) @(posedge clk); #1;
            check("b2b_beats", dq.size(), 3);
            if (dq.size() == 3) begin
                check("b2b_latency", tq[0], acc0 + 1);
                check("b2b_cont1", tq[1], tq[0] + 1);
                check("b2b_cont2", tq[2], tq[1] + 1);
                check("b2b_order", dq[2][31:0], 32'd2);
            end
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/xbar_peri_nx.md
XBAR_PERI_NX -- requirements
Module: xbar_peri_nx

Interface
REQ-001 SHALL have parameter N_SLV, default 4, number of peripheral slave ports (1..8).
REQ-002 SHALL have parameters ADDR_WIDTH 32, DATA_WIDTH 32, MASK_WIDTH DATA_WIDTH/8, SIZE_WIDTH 3, SRC_WIDTH 2, SINK_WIDTH 1, OPCODE_WIDTH 3, PARAM_WIDTH 3: TileLink-UL field widths.
REQ-003 SHALL have parameters SLV_BASE and SLV_MASK, each N_SLV*ADDR_WIDTH, default slave i base 0x1000_0000+i*0x1000, mask 0xFFFF_F000: address map.
REQ-004 SHALL have parameter MAX_OUT, default 4, maximum outstanding requests (1..15).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 Ports: clk  in  1  clock.
REQ-007 Ports: reset  in  1  asynchronous active-low reset.
REQ-008 Ports: a_valid/a_ready  in/out  1  host A handshake; a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data  in  field widths  host A fields.
REQ-009 Ports: d_valid/d_ready  out/in  1  host D handshake; d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error  out  field widths  host D fields.
REQ-010 Ports: a_valid_out/a_ready_out  out/in  N_SLV  per-slave A handshake; a_*_out  out  field widths  A fields broadcast to all slaves.
REQ-011 Ports: d_valid_in/d_ready_in  in/out  N_SLV  per-slave D handshake; d_*_in  in  N_SLV*field width  per-slave D fields, slave i at slice i.

Function
REQ-012 Decode: slave i hit when (a_address & SLV_MASK[i]) == SLV_BASE[i]; lowest hit index wins; no hit = unmapped.
REQ-013 A routing: a_valid_out[t] = a_valid & gate for decoded target t only; a_ready = a_ready_out[t] & gate; fields pass combinationally.
REQ-014 Gate open only when out_cnt < MAX_OUT and (out_cnt == 0 or target == cur_tgt); else a_ready=0 and all a_valid_out=0 (responses never reorder).
REQ-015 On A fire: cur_tgt <= target (index N_SLV denotes unmapped); out_cnt increments.
REQ-016 On D fire (d_valid & d_ready): out_cnt decrements; simultaneous A and D fire leaves out_cnt unchanged.
REQ-017 D path: d_* and d_valid driven from slave cur_tgt; d_ready_in[cur_tgt] = d_ready; other d_ready_in = 0; d_valid_in from non-current slaves ignored.
REQ-018 Unmapped: internal error responder accepts A only when out_cnt == 0 (a_ready=1), then presents D next cycle: d_error=1, d_opcode=1 (AccessAckData) for Get (4), else 0 (AccessAck); d_source and d_size echoed; d_data=0; d_param=0; d_sink=0.
REQ-019 Error responder holds D until d_ready, then idle; accepts no A while busy.
REQ-020 d_valid SHALL NOT depend combinationally on d_ready; a_valid_out SHALL NOT depend on a_ready_out.

Reset
REQ-021 Asynchronous assertion (reset=0): out_cnt=0, cur_tgt=0, error responder idle, output register (if present) empty.
REQ-022 During and after reset until first A: d_valid=0, all a_valid_out=0, all d_ready_in=0, a_ready=0 while reset asserted.
REQ-023 Reset mid-transaction discards in-flight state; no D is issued for pre-reset requests.

Configuration
REQ-024 Macro XBAR_PERI_D_REG_EN: when defined, D channel passes a 2-entry skid register; +1 cycle D latency, d_ready_in[cur_tgt] = register not full, full throughput.
REQ-025 Without XBAR_PERI_D_REG_EN, D path combinational per REQ-017, zero added latency; out_cnt decrements on host-side D fire in both cases.

Verification
REQ-026 Get 0x1000_1004, slave1 answers data 0xCAFE_0001 -> a_valid_out=4'b0010, host sees d_data 0xCAFE_0001, d_error 0, out_cnt back to 0.
REQ-027 Get 0x2000_0000 (unmapped), source 2 -> no a_valid_out, next cycle d_valid, d_opcode 1, d_error 1, d_source 2, d_data 0.
REQ-028 Four Puts to slave0, slave0 D stalled -> 5th request stalls a_ready=0 at out_cnt=4; one D fire -> 5th accepted.
REQ-029 Request to slave0 outstanding, next request to slave2 -> blocked until slave0 D fires, then slave2 routed.
REQ-030 reset=0 asserted with out_cnt=2 -> out_cnt=0, d_valid=0 immediately; post-reset Get to slave3 completes normally.
REQ-031 Build with XBAR_PERI_D_REG_EN, back-to-back Gets to slave1, d_ready held 1 -> one D per cycle after one extra cycle latency.
